// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and constants for the instruction-RAM load arbiter.
package imem_pkg;
  localparam int AW_DEF        = 6;
  localparam int STEAL_MAX_DEF = 4;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_HALT = 5'd1;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [15:0] insn);
    return insn[15:11] == OP_HALT;
  endfunction
endpackage

// File: rtl/imem_load_arbiter_if.sv
// Bus bundle between the instruction RAM arbiter and its fetch, loader and debug users.
interface imem_load_arbiter_if #(parameter int AW = imem_pkg::AW_DEF);
  logic [15:0]   i_addr;
  logic          fetch_en;
  logic [15:0]   i_out;
  logic          cpu_stall;
  logic          ld_start;
  logic          ld_valid;
  logic [15:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   ld_count;
  logic          ld_err;
  logic          dbg_rd_req;
  logic [AW-1:0] dbg_rd_addr;
  logic [15:0]   dbg_rd_data;
  logic          dbg_rd_valid;
  logic          halted;
  logic          addr_fault;

  modport slave (
    input  i_addr, fetch_en, ld_start, ld_valid, ld_data, ld_done, dbg_rd_req, dbg_rd_addr,
    output i_out, cpu_stall, ld_ready, ld_count, ld_err, dbg_rd_data, dbg_rd_valid,
           halted, addr_fault
  );

  modport master (
    output i_addr, fetch_en, ld_start, ld_valid, ld_data, ld_done, dbg_rd_req, dbg_rd_addr,
    input  i_out, cpu_stall, ld_ready, ld_count, ld_err, dbg_rd_data, dbg_rd_valid,
           halted, addr_fault
  );
endinterface

// File: rtl/imem_load_arbiter_ram.sv
// Instruction RAM: one synchronous write port, one combinational read port whose
// address is switched between the fetch and debug sides.
module imem_ram #(
  parameter int AW = imem_pkg::AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] fetch_addr,
  input  logic [AW-1:0] dbg_addr,
  input  logic          dbg_sel,
  output logic [15:0]   rdata
);
  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[dbg_sel ? dbg_addr : fetch_addr];
endmodule

// File: rtl/imem_load_arbiter.sv
// Sequences the instruction RAM between the host loader, the CPU fetch stage and a
// debug read port that steals a fetch slot after waiting STEAL_MAX cycles.
// state | meaning: BOOT stalled idle, LOAD host writing, RUN fetching, HALTED stopped on HALT
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int STEAL_MAX = STEAL_MAX_DEF
) (
  input logic                clk,
  input logic                r_st,
  imem_load_arbiter_if.slave bus
);
  localparam int CW = $clog2(STEAL_MAX + 1);

  state_t        state;
  logic [AW:0]   ld_count;
  logic          ld_err;
  logic [CW-1:0] wait_cnt;
  logic          dbg_rd_valid;
  logic [15:0]   dbg_rd_data;
  logic          addr_fault;

  logic          addr_ok;
  logic          fetch_busy;
  logic          ld_ready;
  logic          wr_en;
  logic          dbg_pending;
  logic          steal;
  logic          grant;
  logic          halt_hit;
  logic [15:0]   rd_data;
  logic [15:0]   i_out;

  assign addr_ok    = (bus.i_addr[15:AW] == '0);
  assign fetch_busy = (state == RUN) && bus.fetch_en;
  assign ld_ready   = (state == LOAD) && !ld_count[AW];
  assign wr_en      = ld_ready && bus.ld_valid && !bus.ld_start;
  // The requester holds dbg_rd_req through its valid pulse; do not serve it twice.
  assign dbg_pending = bus.dbg_rd_req && !dbg_rd_valid;
  assign steal       = dbg_pending && fetch_busy && (wait_cnt == CW'(STEAL_MAX));
  assign grant       = dbg_pending && !wr_en && (!fetch_busy || steal);
  assign i_out       = addr_ok ? rd_data : {OP_NOP, 11'd0};
  assign halt_hit    = fetch_busy && !steal && addr_ok && is_halt(i_out);

  imem_ram #(.AW(AW)) u_ram (
    .clk       (clk),
    .we        (wr_en),
    .waddr     (ld_count[AW-1:0]),
    .wdata     (bus.ld_data),
    .fetch_addr(bus.i_addr[AW-1:0]),
    .dbg_addr  (bus.dbg_rd_addr),
    .dbg_sel   (grant),
    .rdata     (rd_data)
  );

  always_ff @(posedge clk or negedge r_st) begin
    if (!r_st) begin
      state        <= BOOT;
      ld_count     <= '0;
      ld_err       <= 1'b0;
      wait_cnt     <= '0;
      dbg_rd_valid <= 1'b0;
      dbg_rd_data  <= '0;
      addr_fault   <= 1'b0;
    end else begin
      dbg_rd_valid <= grant;
      addr_fault   <= fetch_busy && !steal && !addr_ok;

      if (grant) begin
        dbg_rd_data <= rd_data;
        wait_cnt    <= '0;
      end else if (dbg_pending && fetch_busy) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else if (!dbg_pending) begin
        wait_cnt <= '0;
      end

      if (bus.ld_start) begin
        ld_count <= '0;
        ld_err   <= 1'b0;
      end else if (wr_en) begin
        ld_count <= ld_count + (AW+1)'(1);
      end else if ((state == LOAD) && bus.ld_valid && ld_count[AW]) begin
        ld_err <= 1'b1;
      end

      case (state)
        BOOT, LOAD, HALTED: begin
          if (bus.ld_start)     state <= LOAD;
          else if (bus.ld_done) state <= RUN;
        end
        RUN: begin
          if (bus.ld_start)  state <= LOAD;
          else if (halt_hit) state <= HALTED;
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.i_out        = i_out;
  assign bus.cpu_stall    = (state != RUN) || steal;
  assign bus.ld_ready     = ld_ready;
  assign bus.ld_count     = ld_count;
  assign bus.ld_err       = ld_err;
  assign bus.dbg_rd_data  = dbg_rd_data;
  assign bus.dbg_rd_valid = dbg_rd_valid;
  assign bus.halted       = (state == HALTED);
  assign bus.addr_fault   = addr_fault;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: fetch vector table, debug-read scoreboard,
// and hand sequences for load overflow, steal timing, HALT and mid-load reset.
`timescale 1ns/1ps
module tb_imem_load_arbiter;
  localparam int AW        = 6;
  localparam int STEAL_MAX = 4;

  logic clk = 1'b0;
  logic r_st;
  always #5 clk = ~clk;

  imem_load_arbiter_if #(.AW(AW)) bus ();
  imem_load_arbiter #(.AW(AW), .STEAL_MAX(STEAL_MAX)) dut (.clk(clk), .r_st(r_st), .bus(bus));

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp_out;
    logic        exp_fault;
  } fvec_t;

  fvec_t       vecs [5];
  logic [15:0] model [64];
  logic [15:0] exp_q [$];
  int          ptr;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    ptr = 0;
  endtask

  task automatic pulse_done();
    bus.ld_done = 1'b1;
    tick();
    bus.ld_done = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.ld_valid = 1'b1;
    bus.ld_data  = w;
    smp();
    chk("ld_ready_word", bus.ld_ready, 1);
    model[ptr] = w;
    ptr++;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_dbg(input int max, output int lat);
    lat = max + 1;
    for (int c = 0; c <= max; c++) begin
      smp();
      if (bus.dbg_rd_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic dbg_read(input logic [AW-1:0] a, input string name);
    int lat;
    bus.dbg_rd_addr = a;
    bus.dbg_rd_req  = 1'b1;
    exp_q.push_back(model[a]);
    wait_dbg(8, lat);
    chk(name, lat, 1);
    tick();
    bus.dbg_rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (r_st === 1'b1 && bus.dbg_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dbg_unexpected actual=%0h required=none", bus.dbg_rd_data);
      end else begin
        chk("dbg_rd_data", bus.dbg_rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt, stall_at, valid_at, lat;
    vecs[0] = '{16'h0000, 16'hD110, 1'b0};
    vecs[1] = '{16'h0001, 16'hD201, 1'b0};
    vecs[2] = '{16'h0002, 16'h2312, 1'b0};
    vecs[3] = '{16'h0040, 16'h0000, 1'b1};
    vecs[4] = '{16'hFFC1, 16'h0000, 1'b1};

    r_st = 1'b0;
    bus.i_addr = '0; bus.fetch_en = 1'b0; bus.ld_start = 1'b0; bus.ld_valid = 1'b0;
    bus.ld_data = '0; bus.ld_done = 1'b0; bus.dbg_rd_req = 1'b0; bus.dbg_rd_addr = '0;
    ptr = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    smp();
    chk("rst_stall", bus.cpu_stall, 1);
    chk("rst_ready", bus.ld_ready, 0);
    chk("rst_count", bus.ld_count, 0);
    chk("rst_err", bus.ld_err, 0);
    chk("rst_dbg_valid", bus.dbg_rd_valid, 0);
    chk("rst_fault", bus.addr_fault, 0);
    chk("rst_halted", bus.halted, 0);
    tick();
    r_st = 1'b1;
    smp();
    chk("boot_stall", bus.cpu_stall, 1);
    chk("boot_ready", bus.ld_ready, 0);
    tick();

    // Three-word load then run
    pulse_start();
    load_word(16'hD110);
    load_word(16'hD201);
    load_word(16'h2312);
    pulse_done();
    bus.i_addr = 16'h0002;
    smp();
    chk("run_stall", bus.cpu_stall, 0);
    chk("run_count", bus.ld_count, 3);
    chk("run_i_out", bus.i_out, 16'h2312);
    tick();

    // Fetch vector table, including out-of-range addresses
    for (int i = 0; i < 5; i++) begin
      bus.i_addr   = vecs[i].addr;
      bus.fetch_en = 1'b1;
      smp();
      chk("vec_i_out", bus.i_out, vecs[i].exp_out);
      chk("vec_stall", bus.cpu_stall, 0);
      tick();
      bus.fetch_en = 1'b0;
      smp();
      chk("vec_fault", bus.addr_fault, vecs[i].exp_fault);
      tick();
      smp();
      chk("vec_fault_end", bus.addr_fault, 0);
      chk("vec_still_run", bus.cpu_stall, 0);
      tick();
    end

    // Debug read steals one fetch slot after STEAL_MAX waits
    bus.i_addr      = 16'h0000;
    bus.fetch_en    = 1'b1;
    bus.dbg_rd_addr = 6'd1;
    bus.dbg_rd_req  = 1'b1;
    exp_q.push_back(model[1]);
    stall_cnt = 0; stall_at = -1; valid_at = -1;
    for (int c = 0; c < 20 && valid_at < 0; c++) begin
      smp();
      if (bus.cpu_stall) begin
        stall_cnt++;
        stall_at = c;
      end
      if (bus.dbg_rd_valid) valid_at = c;
    end
    tick();
    bus.dbg_rd_req = 1'b0;
    bus.fetch_en   = 1'b0;
    chk("steal_stall_cnt", stall_cnt, 1);
    chk("steal_at", stall_at, STEAL_MAX);
    chk("steal_valid_at", valid_at, STEAL_MAX + 1);

    // Reload with HALT at 3; debug read of a word being written the cycle before
    pulse_start();
    load_word(16'hD110);
    load_word(16'hD201);
    load_word(16'h2312);
    bus.ld_valid    = 1'b1;
    bus.ld_data     = 16'h0800;
    bus.dbg_rd_addr = 6'd3;
    bus.dbg_rd_req  = 1'b1;
    model[3] = 16'h0800;
    ptr++;
    exp_q.push_back(16'h0800);
    tick();
    bus.ld_valid = 1'b0;
    wait_dbg(8, lat);
    chk("raw_dbg_lat", lat, 1);
    tick();
    bus.dbg_rd_req = 1'b0;
    pulse_done();

    for (int a = 0; a < 4; a++) begin
      bus.i_addr   = 16'(a);
      bus.fetch_en = 1'b1;
      smp();
      chk("pc_walk_halted", bus.halted, 0);
      chk("pc_walk_stall", bus.cpu_stall, 0);
      tick();
    end
    bus.fetch_en = 1'b0;
    smp();
    chk("halt_halted", bus.halted, 1);
    chk("halt_stall", bus.cpu_stall, 1);
    tick();
    dbg_read(6'd2, "halted_dbg_lat");
    pulse_done();
    smp();
    chk("restart_halted", bus.halted, 0);
    chk("restart_stall", bus.cpu_stall, 0);
    tick();

    // ld_start and ld_done together: start wins; then fill RAM and overflow
    bus.ld_start = 1'b1;
    bus.ld_done  = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_done  = 1'b0;
    ptr = 0;
    smp();
    chk("start_wins_ready", bus.ld_ready, 1);
    chk("start_wins_stall", bus.cpu_stall, 1);
    tick();
    for (int i = 0; i < 64; i++) load_word(16'h3000 | 16'(i));
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hBEEF;
    smp();
    chk("full_ready", bus.ld_ready, 0);
    tick();
    bus.ld_valid = 1'b0;
    smp();
    chk("full_err", bus.ld_err, 1);
    chk("full_count", bus.ld_count, 64);
    tick();
    smp();
    chk("err_sticky", bus.ld_err, 1);
    tick();
    dbg_read(6'd0, "full_dbg0_lat");
    dbg_read(6'd63, "full_dbg63_lat");
    pulse_start();
    smp();
    chk("restart_err", bus.ld_err, 0);
    chk("restart_count", bus.ld_count, 0);
    tick();

    // Reset asserted mid-cycle during a load
    load_word(16'h4000);
    load_word(16'h4001);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hAAAA;
    #2;
    r_st = 1'b0;
    #1;
    chk("midrst_count", bus.ld_count, 0);
    chk("midrst_ready", bus.ld_ready, 0);
    chk("midrst_stall", bus.cpu_stall, 1);
    chk("midrst_dbg_valid", bus.dbg_rd_valid, 0);
    chk("midrst_fault", bus.addr_fault, 0);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    #3;
    r_st = 1'b1;
    tick();
    dbg_read(6'd2, "midrst_dbg_lat");
    dbg_read(6'd1, "midrst_dbg1_lat");

    tick();
    smp();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
